// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with a start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic                  Busy,
  output logic                  Done,
  output logic [BIN_W-1:0]      Bin,
  output logic                  Err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state;
  logic [4*DIGITS-1:0] word;
  logic [BIN_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                err_int;

  logic [3:0]          digit;
  logic [BIN_W+3:0]    acc_wide;
  logic [BIN_W-1:0]    acc_next;
  logic                err_next;

  // Multiply by ten as shift-and-add in a widened datapath, then wrap.
  always_comb begin
    digit    = word[{cnt, 2'b00} +: 4];
    acc_wide = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
             + {{BIN_W{1'b0}}, digit};
    acc_next = acc_wide[BIN_W-1:0];
    err_next = err_int | (digit > 4'd9);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state   <= IDLE;
      word    <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_int <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Bin     <= '0;
      Err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            word    <= BCD;
            acc     <= '0;
            cnt     <= CNT_W'(DIGITS - 1);
            err_int <= 1'b0;
            Busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          acc     <= acc_next;
          err_int <= err_next;
          if (cnt == '0) begin
            // Any invalid digit forces the published result to zero.
            Bin   <= err_next ? '0 : acc_next;
            Err   <= err_next;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (4-digit and 2-digit builds).
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] bcd;
  logic        busy, done, err;
  logic [13:0] bin;

  logic        start2;
  logic [7:0]  bcd2;
  logic        busy2, done2, err2;
  logic [6:0]  bin2;

  int checks = 0;
  int passes = 0;
  logic [13:0] prev_bin;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .Clock(clk), .Resetn(resetn), .Start(start), .BCD(bcd),
    .Busy(busy), .Done(done), .Bin(bin), .Err(err)
  );

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .Clock(clk), .Resetn(resetn), .Start(start2), .BCD(bcd2),
    .Busy(busy2), .Done(done2), .Bin(bin2), .Err(err2)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulse Start for one edge, then follow the fixed 4-digit timeline.
  task automatic convert(input string tag, input logic [15:0] word,
                         input logic [13:0] exp_bin, input logic exp_err);
    bcd   = word;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      check({tag, "_bin_hold"}, bin, prev_bin);
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_lo"}, busy, 1'b0);
    check({tag, "_bin"}, bin, exp_bin);
    check({tag, "_err"}, err, exp_err);
    tick();
    check({tag, "_done_lo"}, done, 1'b0);
    check({tag, "_bin_kept"}, bin, exp_bin);
    prev_bin = exp_bin;
    $display("conv %s bcd=%h bin=%0d err=%0b", tag, word, bin, err);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; bcd = '0; start2 = 1'b0; bcd2 = '0;
    prev_bin = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bin", bin, 14'd0);
    check("rst_err", err, 1'b0);
    resetn = 1'b1;
    tick();

    convert("c1234", 16'h1234, 14'd1234, 1'b0);
    convert("c9999", 16'h9999, 14'd9999, 1'b0);
    convert("c0000", 16'h0000, 14'd0, 1'b0);
    convert("c12A4", 16'h12A4, 14'd0, 1'b1);
    convert("c0042", 16'h0042, 14'd42, 1'b0);

    // Start and BCD changes during Busy and in the Done cycle are ignored.
    bcd = 16'h0500; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bcd = 16'h0777; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ign_done", done, 1'b1);
    check("ign_bin", bin, 14'd500);
    start = 1'b1;
    tick();
    check("ign_done_lo", done, 1'b0);
    check("ign_busy_after_done", busy, 1'b0);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("ign_no_second_done", done, 1'b0);
      check("ign_idle", busy, 1'b0);
    end
    prev_bin = 14'd500;
    $display("conv ignore bin=%0d", bin);

    // Reset mid-conversion aborts without a Done pulse.
    bcd = 16'h8765; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_bin", bin, 14'd0);
    check("abort_err", err, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_done", done, 1'b0);
    end
    prev_bin = '0;
    $display("conv abort bin=%0d", bin);
    convert("c0031", 16'h0031, 14'd31, 1'b0);

    // Start held high: Done every 6 cycles, 4 edges after each accept.
    bcd = 16'h0100; start = 1'b1;
    tick();
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("held_done", done, (i % 6) == 4);
      if ((i % 6) == 4) begin
        check("held_bin", bin, 14'd100);
        $display("conv held cycle=%0d bin=%0d", i, bin);
      end
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Two-digit build.
    bcd2 = 8'h99; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("d2_busy", busy2, 1'b1);
    tick();
    check("d2_nodone", done2, 1'b0);
    tick();
    check("d2_done", done2, 1'b1);
    check("d2_bin", bin2, 7'd99);
    check("d2_err", err2, 1'b0);
    $display("conv d2 bcd=%h bin=%0d err=%0b", bcd2, bin2, err2);
    tick();
    check("d2_done_lo", done2, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter: the inverse of the lab's binary-to-BCD digit-splitting path. It accepts a packed multi-digit BCD word from the switches or a BCD adder and produces its unsigned binary value. It processes one digit per clock, most-significant digit first, using acc = acc*10 + digit. A start/busy/done handshake lets a controller or the 7-seg display path consume the result.

Parameters:
DIGITS, 4, number of BCD digits in the input word (1..6)
BIN_W, 14, width of the binary result; must be >= ceil(log2(10^DIGITS)); 14 covers 9999

Ports:
Clock  input  1  system clock, rising-edge active
Resetn  input  1  synchronous active-low reset
Start  input  1  request conversion; sampled only in IDLE
BCD  input  4*DIGITS  packed BCD; digit i occupies BCD[4i+3:4i], digit DIGITS-1 is most significant
Busy  output  1  high while converting
Done  output  1  one-cycle pulse when Bin/Err are valid
Bin  output  BIN_W  binary result, held until next accepted Start
Err  output  1  invalid-digit flag for last conversion, held with Bin

Behaviour:
- Reset: Clock and Resetn are the only clock/reset. Reset is synchronous and active-low. Resetn=0 at a rising edge forces state IDLE, Busy=0, Done=0, Bin=0, Err=0, internal acc=0, digit counter=0, latched word=0.
- Reset mid-conversion aborts immediately. No Done is produced, and outputs return to reset values.
- States: IDLE, CONVERT, DONE.
- IDLE, Start=1 at edge E0:
  - latch BCD into an internal register; later BCD changes are ignored
  - acc<=0, cnt<=DIGITS-1, err_int<=0
  - state->CONVERT, Busy<=1
- IDLE, Start=0: remain in IDLE.
- CONVERT, each edge:
  - d = latched digit[cnt]
  - acc <= (acc*10 + d) truncated to BIN_W bits (mod 2^BIN_W)
  - if d>9, err_int<=1 (sticky for this conversion); d is still accumulated internally
  - if cnt==0: state->DONE; Bin <= final acc, or 0 if any invalid digit was seen; Err <= final error; Busy<=0; Done<=1
  - otherwise cnt<=cnt-1
- DONE: lasts exactly one cycle with Done=1, then state->IDLE and Done<=0. Start is ignored in DONE.
- Latency:
  - Start sampled at E0; digits consumed at edges E1..E_DIGITS.
  - Bin/Err/Done update at edge E_DIGITS, so Done is high in the cycle after E_DIGITS (4 cycles after E0 for DIGITS=4).
  - Busy is high from after E0 through the cycle before E_DIGITS.
  - Next Start is accepted no earlier than E_DIGITS+2; minimum repeat period is DIGITS+2 cycles.
- Start held high continuously: a new conversion begins every DIGITS+2 cycles.
- Start while Busy or in DONE: ignored, with no effect on the running conversion.
- Arithmetic:
  - acc*10 is implemented as (acc<<3)+(acc<<1), computed BIN_W+4 bits wide, then truncated.
  - With legal parameters and valid digits, truncation never occurs.
- Bin and Err change only at reset or at the final CONVERT edge. They are stable at all other times.

Test Plan:
- Reset, then BCD=16'h1234, Start pulse 1 cycle -> Busy high 4 cycles; Done single pulse 4 cycles after the Start edge; Bin=14'd1234 (0x04D2), Err=0.
- BCD=16'h9999 -> Bin=14'd9999 (0x270F), Err=0; BCD=16'h0000 -> Bin=0, Err=0, Done still pulses after 4 cycles.
- BCD=16'h12A4 (invalid digit A) -> Done pulses; Bin=0, Err=1. A following conversion of 16'h0042 -> Bin=42, Err=0 (error flag not carried over).
- Start 16'h0500; during Busy change BCD to 16'h0777 and pulse Start again -> Bin=500, exactly one Done pulse. Start in the Done cycle is also ignored.
- Start 16'h8765, assert Resetn=0 for one edge after 2 cycles -> Busy=0, Done never pulses, Bin=0. Then a fresh conversion of 16'h0031 -> Bin=31.
- Start held high with BCD=16'h0100 -> Done pulses every 6 cycles with Bin=100 each time. Repeat with DIGITS=2, BIN_W=7, BCD=8'h99 -> Bin=99 after 2 cycles.
